// File: rtl/dcm_reset_ctrl_pkg.sv
// Shared types and defaults for the DCM reset sequencer.
package dcm_reset_ctrl_pkg;

  localparam int unsigned DefRstCycles    = 8;
  localparam int unsigned DefLockTimeout  = 1024;
  localparam int unsigned DefSettleCycles = 16;
  localparam int unsigned DefMaxRetries   = 4;

  // Consecutive lock-low cycles needed to declare loss when the glitch filter is built in.
  localparam int unsigned GlitchLen = 4;

  typedef enum logic [2:0] {
    StDcmRst,
    StWaitLock,
    StSettle,
    StRun,
    StFail
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; clears to 0 on synchronous reset.
module sync_2ff (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dcm_reset_ctrl.sv
// DCM reset sequencer: pulses DCM RESET, waits for LOCKED, settles, then releases rst_out.
// Build macro DCM_RST_CTRL_GLITCH_FILTER_EN debounces short lock drops in SETTLE/RUN.
module dcm_reset_ctrl
  import dcm_reset_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DefRstCycles,
  parameter int unsigned LOCK_TIMEOUT  = DefLockTimeout,
  parameter int unsigned SETTLE_CYCLES = DefSettleCycles,
  parameter int unsigned MAX_RETRIES   = DefMaxRetries
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               locked_in,
  output logic                               dcm_reset,
  output logic                               rst_out,
  output logic                               ready,
  output logic                               fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
);

  localparam int unsigned TimerW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES));
  localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);
  localparam int unsigned LossW  = $clog2(GlitchLen);
`ifdef DCM_RST_CTRL_GLITCH_FILTER_EN
  localparam bit FilterEn = 1'b1;
`else
  localparam bit FilterEn = 1'b0;
`endif
  localparam int unsigned LossLen = FilterEn ? GlitchLen : 1;

  localparam logic [TimerW-1:0] RstLast    = TimerW'(RST_CYCLES - 1);
  localparam logic [TimerW-1:0] LockLast   = TimerW'(LOCK_TIMEOUT - 1);
  localparam logic [TimerW-1:0] SettleLast = TimerW'(SETTLE_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryLast  = RetryW'(MAX_RETRIES - 1);
  localparam logic [LossW-1:0]  LossLast   = LossW'(LossLen - 1);

  logic              locked_s;
  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d, timer_inc;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [LossW-1:0]  loss_q, loss_d;
  logic              in_lock_st, lock_lost;
  logic              dcm_reset_q, dcm_reset_d;
  logic              rst_out_q, rst_out_d;
  logic              ready_q, ready_d;
  logic              fail_q, fail_d;

  sync_2ff u_lock_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (locked_in),
    .q_o     (locked_s)
  );

  // Lock is only declared lost after LossLen consecutive low samples.
  assign in_lock_st = (state_q == StSettle) || (state_q == StRun);
  assign lock_lost  = in_lock_st && !locked_s && (loss_q == LossLast);
  assign loss_d     = (in_lock_st && !locked_s && !lock_lost) ? loss_q + 1'b1 : '0;
  assign timer_inc  = (timer_q == '1) ? timer_q : timer_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StDcmRst;
      timer_q     <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      dcm_reset_q <= 1'b1;
      rst_out_q   <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      dcm_reset_q <= dcm_reset_d;
      rst_out_q   <= rst_out_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_inc;
    retry_d = retry_q;
    case (state_q)
      StDcmRst: begin
        if (timer_q == RstLast) begin
          state_d = StWaitLock;
          timer_d = '0;
        end
      end
      StWaitLock: begin
        // A lock seen on the timeout cycle still wins.
        if (locked_s) begin
          state_d = StSettle;
          timer_d = '0;
        end else if (timer_q == LockLast) begin
          timer_d = '0;
          if (retry_q == RetryLast) begin
            state_d = StFail;
          end else begin
            state_d = StDcmRst;
            retry_d = retry_q + 1'b1;
          end
        end
      end
      StSettle: begin
        if (lock_lost) begin
          state_d = StDcmRst;
          timer_d = '0;
        end else if (timer_q == SettleLast) begin
          state_d = StRun;
          timer_d = '0;
          retry_d = '0;
        end
      end
      StRun: begin
        timer_d = '0;
        if (lock_lost) begin
          state_d = StDcmRst;
        end
      end
      StFail: begin
        timer_d = '0;
      end
      default: begin
        state_d = StDcmRst;
        timer_d = '0;
      end
    endcase
  end

  // Outputs decode the upcoming state so they switch on the same edge as the state.
  always_comb begin
    dcm_reset_d = 1'b0;
    rst_out_d   = 1'b1;
    ready_d     = 1'b0;
    fail_d      = 1'b0;
    case (state_d)
      StDcmRst: dcm_reset_d = 1'b1;
      StRun: begin
        rst_out_d = 1'b0;
        ready_d   = 1'b1;
      end
      StFail:   fail_d = 1'b1;
      default: ;
    endcase
  end

  assign dcm_reset = dcm_reset_q;
  assign rst_out   = rst_out_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;

endmodule
